// File: rtl/if_stage.sv
// if_stage: single-outstanding instruction fetch with redirect and decode handoff
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_allowin,
  output logic        if_validout,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
  state_t      state, state_n;
  logic [31:0] pc, pc_n, inst_buf, inst_buf_n;
  logic        discard, discard_n;
  assign inst_req    = state == REQ;
  assign inst_addr   = pc;
  assign if_validout = state == HOLD && !br_taken;
  assign if_pc       = pc;
  assign if_inst     = inst_buf;
  // state register; reset abandons any request in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      inst_buf <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      discard  <= discard_n;
      inst_buf <= inst_buf_n;
    end
  end
  // next state: a redirect overrides every other event and marks any in-flight response stale
  always_comb begin
    state_n    = state;
    pc_n       = br_taken ? br_target : pc;
    discard_n  = discard;
    inst_buf_n = inst_buf;
    case (state)
      REQ: begin
        state_n   = inst_addr_ok ? WAIT : REQ;
        discard_n = inst_addr_ok ? br_taken : discard;
      end
      WAIT: begin
        state_n    = !inst_data_ok ? WAIT : (discard || br_taken) ? REQ : HOLD;
        discard_n  = inst_data_ok ? 1'b0 : discard || br_taken;
        inst_buf_n = (inst_data_ok && !discard && !br_taken) ? inst_rdata : inst_buf;
      end
      HOLD: begin
        state_n = (br_taken || id_allowin) ? REQ : HOLD;
        pc_n    = br_taken ? br_target : id_allowin ? pc + 32'd4 : pc;
      end
      default: state_n = REQ;
    endcase
  end
endmodule
